ps2_kbd_rx: RTL and testbench

Core-side PS/2 keyboard receiver for the emulated keyboard link driven by the HPS I/O block. It deserialises 11-bit frames on `ps2_kbd_clk`/`ps2_kbd_data`, checks odd parity and the stop bit, and decodes the E0/F0 prefixes. It emits one-cycle key events in the `clk_sys` domain for the machine keyboard matrix.

---
 rtl/ps2_kbd_rx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decode (optional ps2_clk glitch filter: PS2_RX_FILTER_EN)
module ps2_kbd_rx #(
    parameter int TIMEOUT    = 20000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic            clk_s1, clk_s2;
    logic            dat_s1, dat_s2;
    logic            clk_line;
    logic            clk_prev;
    logic            fall;
    state_t          state;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic            par_bit;
    logic [WD_W-1:0] wd_cnt;
    logic            ext_flag;
    logic            rel_flag;

    // Two-stage synchronisers; the clock line resets to its idle-high level
    // so that leaving reset never looks like a falling edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

`ifdef PS2_RX_FILTER_EN
    localparam int FC_W = $clog2(FILTER_LEN + 1);

    logic [FC_W-1:0] filt_cnt;
    logic            clk_filt;

    // Glitch filter: the filtered level follows only after FILTER_LEN
    // consecutive samples that differ from it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            filt_cnt <= '0;
            clk_filt <= 1'b1;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_W'(FILTER_LEN - 1)) begin
            filt_cnt <= '0;
            clk_filt <= clk_s2;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign clk_line = clk_filt;
`else
    assign clk_line = clk_s2;
`endif

    // Previous clock level, used to spot a 1 -> 0 transition.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_line;
        end
    end

    assign fall = clk_prev & ~clk_line;

    // Frame receiver FSM with watchdog; result pulses are registered so they
    // appear the cycle after the stop edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            par_bit    <= 1'b0;
            wd_cnt     <= '0;
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (fall) begin
                wd_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            shift   <= 8'h00;
                            bit_cnt <= 3'd0;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!dat_s2) begin
                            frame_err <= 1'b1;
                        end else if (!(^{shift, par_bit})) begin
                            parity_err <= 1'b1;
                        end else begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (wd_cnt == WD_W'(TIMEOUT)) begin
                    state     <= S_IDLE;
                    frame_err <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

    // Prefix decode: E0/F0 arm flags, any other byte emits a key event.
    // Errors drop pending prefixes so they never attach to a later key.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            key_strobe   <= 1'b0;
            key_code     <= 8'h00;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (parity_err || frame_err) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else begin
                    key_code     <= rx_byte;
                    key_pressed  <= ~rel_flag;
                    key_extended <= ext_flag;
                    key_strobe   <= 1'b1;
                    ext_flag     <= 1'b0;
                    rel_flag     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - testbench for ps2_kbd_rx
module tb_ps2_kbd_rx;

    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk_sys;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_pressed;
    logic       key_extended;
    logic       parity_err;
    logic       frame_err;

    int n_total = 0;
    int n_pass  = 0;
    int c_rxv = 0, c_key = 0, c_par = 0, c_frm = 0, c_wide = 0;
    logic p_rxv = 0, p_key = 0, p_par = 0, p_frm = 0;

    ps2_kbd_rx #(.TIMEOUT(TO), .FILTER_LEN(8)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Pulse counters and width watch, sampled away from the active edge.
    always @(negedge clk_sys) begin
        if (rx_valid)   c_rxv++;
        if (key_strobe) c_key++;
        if (parity_err) c_par++;
        if (frame_err)  c_frm++;
        if ((rx_valid && p_rxv) || (key_strobe && p_key) ||
            (parity_err && p_par) || (frame_err && p_frm)) c_wide++;
        p_rxv = rx_valid;
        p_key = key_strobe;
        p_par = parity_err;
        p_frm = frame_err;
    end

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        int         d_rxv, d_key, d_par, d_frm;
        logic [7:0] e_rx, e_code;
        logic       e_pr, e_ext;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ par_flip);
        send_bit(stop);
        ps2_data = 1'b1;
    endtask

    task automatic check_key(input string tag, input logic [7:0] code, input logic pr, input logic ext);
        @(negedge clk_sys);
        check({tag, " key_code"}, {24'h0, key_code}, {24'h0, code});
        check({tag, " key_pressed"}, {31'h0, key_pressed}, {31'h0, pr});
        check({tag, " key_extended"}, {31'h0, key_extended}, {31'h0, ext});
    endtask

    initial begin
        int b_rxv, b_key, b_par, b_frm;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 1, 0, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 0, 0, 8'hE0, 8'h1C, 1'b1, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 0, 8'hF0, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'h75, 1'b0, 1'b1, 1, 1, 0, 0, 8'h75, 8'h75, 1'b0, 1'b1};
        vecs[4]  = '{8'h75, 1'b0, 1'b1, 1, 1, 0, 0, 8'h75, 8'h75, 1'b1, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 0, 8'hF0, 8'h75, 1'b1, 1'b0};
        vecs[6]  = '{8'h1C, 1'b1, 1'b1, 0, 0, 1, 0, 8'hF0, 8'h75, 1'b1, 1'b0};
        vecs[7]  = '{8'h1C, 1'b0, 1'b1, 1, 1, 0, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
        vecs[8]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 0, 0, 8'hE0, 8'h1C, 1'b1, 1'b0};
        vecs[9]  = '{8'h1C, 1'b0, 1'b0, 0, 0, 0, 1, 8'hE0, 8'h1C, 1'b1, 1'b0};
        vecs[10] = '{8'h29, 1'b0, 1'b1, 1, 1, 0, 0, 8'h29, 8'h29, 1'b1, 1'b0};
        vecs[11] = '{8'h5A, 1'b0, 1'b1, 1, 1, 0, 0, 8'h5A, 8'h5A, 1'b1, 1'b0};

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(4);
        @(negedge clk_sys);
        check("reset outputs",
              {rx_byte, key_code, key_pressed, key_extended, rx_valid, key_strobe, parity_err, frame_err},
              32'h0);
        reset = 1'b0;
        wait_cyc(10);

        for (int i = 0; i < 12; i++) begin
            b_rxv = c_rxv; b_key = c_key; b_par = c_par; b_frm = c_frm;
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop);
            wait_cyc(5);
            @(negedge clk_sys);
            check($sformatf("v%0d rx_valid count", i), c_rxv - b_rxv, vecs[i].d_rxv);
            check($sformatf("v%0d key_strobe count", i), c_key - b_key, vecs[i].d_key);
            check($sformatf("v%0d parity_err count", i), c_par - b_par, vecs[i].d_par);
            check($sformatf("v%0d frame_err count", i), c_frm - b_frm, vecs[i].d_frm);
            check($sformatf("v%0d rx_byte", i), {24'h0, rx_byte}, {24'h0, vecs[i].e_rx});
            check($sformatf("v%0d key_code", i), {24'h0, key_code}, {24'h0, vecs[i].e_code});
            check($sformatf("v%0d key_pressed", i), {31'h0, key_pressed}, {31'h0, vecs[i].e_pr});
            check($sformatf("v%0d key_extended", i), {31'h0, key_extended}, {31'h0, vecs[i].e_ext});
        end

        // Timeout: E0 armed, frame aborted after 4 data bits, then a clean 0x29.
        send_frame(8'hE0, 1'b0, 1'b1);
        b_rxv = c_rxv; b_frm = c_frm;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_cyc(TO + 10);
        @(negedge clk_sys);
        check("timeout frame_err count", c_frm - b_frm, 1);
        check("timeout rx_valid count", c_rxv - b_rxv, 0);
        b_key = c_key;
        send_frame(8'h29, 1'b0, 1'b1);
        wait_cyc(5);
        check("after timeout key count", c_key - b_key, 1);
        check_key("after timeout", 8'h29, 1'b1, 1'b0);

        // Reset mid-frame with F0 pending.
        send_frame(8'hF0, 1'b0, 1'b1);
        b_rxv = c_rxv; b_key = c_key; b_par = c_par; b_frm = c_frm;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        reset = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        @(negedge clk_sys);
        check("midreset outputs",
              {rx_byte, key_code, key_pressed, key_extended, rx_valid, key_strobe, parity_err, frame_err},
              32'h0);
        reset = 1'b0;
        wait_cyc(TO + 20);
        @(negedge clk_sys);
        check("midreset no pulses", (c_rxv - b_rxv) + (c_key - b_key) + (c_par - b_par) + (c_frm - b_frm), 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cyc(5);
        check("after reset key count", c_key - b_key, 1);
        check_key("after reset", 8'h5A, 1'b1, 1'b0);

        // Back-to-back frames with no idle gap.
        b_key = c_key;
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        wait_cyc(5);
        check("b2b key count", c_key - b_key, 2);
        check_key("b2b", 8'h32, 1'b1, 1'b0);

        // 3-cycle low glitch on an idle clock line with data low.
        wait_cyc(20);
        b_rxv = c_rxv; b_frm = c_frm;
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(TO + 20);
        ps2_data = 1'b1;
        @(negedge clk_sys);
`ifdef PS2_RX_FILTER_EN
        check("glitch frame_err count", c_frm - b_frm, 0);
`else
        check("glitch frame_err count", c_frm - b_frm, 1);
`endif
        check("glitch rx_valid count", c_rxv - b_rxv, 0);

        check("pulse width", c_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
